// File: rtl/regfile_2r1w.sv
// regfile_2r1w: parametrised register file with one byte-strobed write port
// and two independent registered read ports (A and B).
//
// Ports:
//   clk                  clock, rising edge
//   rst                  synchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_strb   write request, address, data, lane enables
//   rd_en_a/rd_addr_a    port A read request and address
//   rd_data_a/valid_a    port A registered read data and valid
//   rd_en_b/rd_addr_b    port B read request and address
//   rd_data_b/valid_b    port B registered read data and valid
//   clr                  start a clear sweep (one entry zeroed per cycle)
//   busy                 clear sweep in progress
//   err                  one-cycle pulse after an out-of-range access
module regfile_2r1w #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int ADDRESS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDRESS-1:0]   wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_strb,
  input  logic                 rd_en_a,
  input  logic [ADDRESS-1:0]   rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  output logic                 valid_a,
  input  logic                 rd_en_b,
  input  logic [ADDRESS-1:0]   rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  output logic                 valid_b,
  input  logic                 clr,
  output logic                 busy,
  output logic                 err
);

  localparam int LANES = WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDRESS still compares correctly.
  localparam logic [ADDRESS:0]   DEPTH_X = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS-1:0] LAST    = ADDRESS'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_n;
  logic [ADDRESS-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 sweep_en;
  logic [ADDRESS-1:0]   sweep_idx;
  logic                 wr_ok, rd_ok_a, rd_ok_b;
  logic                 rd_oob_a, rd_oob_b, err_n;
  logic [WIDTH-1:0]     wr_merged, rd_val_a, rd_val_b;

  function automatic logic in_range(input logic [ADDRESS-1:0] addr);
    return {1'b0, addr} < DEPTH_X;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and access qualification; clr in IDLE outranks reads/writes.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sweep_en  = 1'b0;
    sweep_idx = '0;
    wr_ok     = 1'b0;
    rd_ok_a   = 1'b0;
    rd_ok_b   = 1'b0;
    rd_oob_a  = 1'b0;
    rd_oob_b  = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          sweep_en  = 1'b1;
          sweep_idx = '0;
          if (DEPTH > 1) begin
            state_n = CLEAR;
            cnt_n   = ADDRESS'(1);
          end
        end else begin
          wr_ok    = wr_en && in_range(wr_addr);
          rd_ok_a  = rd_en_a && in_range(rd_addr_a);
          rd_ok_b  = rd_en_b && in_range(rd_addr_b);
          rd_oob_a = rd_en_a && !in_range(rd_addr_a);
          rd_oob_b = rd_en_b && !in_range(rd_addr_b);
          err_n    = (wr_en && !in_range(wr_addr)) || rd_oob_a || rd_oob_b;
        end
      end
      CLEAR: begin
        sweep_en  = 1'b1;
        sweep_idx = cnt;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ADDRESS'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  // Merged write word, also forwarded to same-address reads (write-first).
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_strb[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  assign rd_val_a = (wr_ok && wr_addr == rd_addr_a) ? wr_merged : mem[rd_addr_a];
  assign rd_val_b = (wr_ok && wr_addr == rd_addr_b) ? wr_merged : mem[rd_addr_b];

  // Storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sweep_en) begin
      mem[sweep_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  // Registered read ports and error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      valid_a   <= 1'b0;
      valid_b   <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid_a <= rd_ok_a;
      valid_b <= rd_ok_b;
      err     <= err_n;
      if (rd_ok_a)       rd_data_a <= rd_val_a;
      else if (rd_oob_a) rd_data_a <= '0;
      if (rd_ok_b)       rd_data_b <= rd_val_b;
      else if (rd_oob_b) rd_data_b <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w. A 16-entry instance (dut)
// and a 12-entry instance (dut12) share all inputs; dut12 covers the
// out-of-range behaviour.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_en_a, rd_en_b;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        clr;

  logic [31:0] rd_data_a, rd_data_b, rd_data_a12, rd_data_b12;
  logic        valid_a, valid_b, busy, err;
  logic        valid_a12, valid_b12, busy12, err12;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(32), .DEPTH(16), .ADDRESS(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .valid_a(valid_a), .rd_en_b(rd_en_b),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .valid_b(valid_b),
    .clr(clr), .busy(busy), .err(err)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(12), .ADDRESS(4)) dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a12), .valid_a(valid_a12), .rd_en_b(rd_en_b),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b12), .valid_b(valid_b12),
    .clr(clr), .busy(busy12), .err(err12)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
    clr = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_a(input logic [3:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
    tick();
    rd_en_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int bad_valid;

    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    check_eq("rst_rd_data_a", rd_data_a, 32'h0);
    check_eq("rst_valid_a",   {31'b0, valid_a}, 32'h0);
    check_eq("rst_busy",      {31'b0, busy}, 32'h0);
    check_eq("rst_err",       {31'b0, err}, 32'h0);
    rst = 1'b1;

    // 1: basic write then dual-port read
    do_write(4'd3, 32'hDEADBEEF, 4'hF);
    rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd5;
    tick();
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    check_eq("rd_a_addr3",  rd_data_a, 32'hDEADBEEF);
    check_eq("valid_a_rd",  {31'b0, valid_a}, 32'h1);
    check_eq("rd_b_addr5",  rd_data_b, 32'h0);
    check_eq("valid_b_rd",  {31'b0, valid_b}, 32'h1);
    check_eq("err_inrange", {31'b0, err}, 32'h0);
    tick();
    check_eq("valid_a_idle", {31'b0, valid_a}, 32'h0);
    check_eq("rd_a_hold",    rd_data_a, 32'hDEADBEEF);

    // 2: byte strobes and the zero-strobe no-op
    do_write(4'd7, 32'h11223344, 4'hF);
    do_write(4'd7, 32'hAABBCCDD, 4'b0101);
    read_a(4'd7);
    check_eq("strb_merge", rd_data_a, 32'h11BB33DD);
    do_write(4'd7, 32'h00000000, 4'b0000);
    read_a(4'd7);
    check_eq("strb_zero_noop", rd_data_a, 32'h11BB33DD);

    // 3: write-first on both ports
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_strb = 4'b1100;
    rd_en_a = 1'b1; rd_addr_a = 4'd2; rd_en_b = 1'b1; rd_addr_b = 4'd2;
    tick();
    idle_inputs();
    check_eq("wf_rd_a",   rd_data_a, 32'h12340000);
    check_eq("wf_rd_b",   rd_data_b, 32'h12340000);
    check_eq("wf_valid_b", {31'b0, valid_b}, 32'h1);
    read_a(4'd2);
    check_eq("wf_stored", rd_data_a, 32'h12340000);

    // 4: out-of-range on the 12-entry instance
    do_write(4'd13, 32'h55555555, 4'hF);
    check_eq("oob_wr_err12", {31'b0, err12}, 32'h1);
    check_eq("oob_wr_err16", {31'b0, err}, 32'h0);
    tick();
    check_eq("oob_err_pulse", {31'b0, err12}, 32'h0);
    read_a(4'd2);
    check_eq("dut12_pre_oob", rd_data_a12, 32'h12340000);
    read_a(4'd15);
    check_eq("oob_rd_valid", {31'b0, valid_a12}, 32'h0);
    check_eq("oob_rd_data",  rd_data_a12, 32'h0);
    check_eq("oob_rd_err",   {31'b0, err12}, 32'h1);
    rd_en_a = 1'b1; rd_addr_a = 4'd3; rd_en_b = 1'b1; rd_addr_b = 4'd7;
    tick();
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    check_eq("oob_keep_a3", rd_data_a12, 32'hDEADBEEF);
    check_eq("oob_keep_b7", rd_data_b12, 32'h11BB33DD);

    // 5: clear sweep, with clr winning over a same-edge write/read
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'hFFFFFFFF, 4'hF);
    clr = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hAAAAAAAA; wr_strb = 4'hF;
    rd_en_a = 1'b1; rd_addr_a = 4'd0;
    tick();
    clr = 1'b0;
    check_eq("clr_start_valid", {31'b0, valid_a}, 32'h0);
    check_eq("clr_start_err",   {31'b0, err}, 32'h0);
    check_eq("clr_start_busy",  {31'b0, busy}, 32'h1);
    // Keep issuing accesses while busy; none may take effect.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h12341234; wr_strb = 4'hF;
    rd_en_a = 1'b1; rd_addr_a = 4'd4; rd_en_b = 1'b1; rd_addr_b = 4'd15;
    n_busy = 0;
    bad_valid = 0;
    while (busy && n_busy < 40) begin
      n_busy++;
      if (valid_a || valid_b || err) bad_valid++;
      tick();
    end
    if (valid_a || valid_b || err) bad_valid++;
    idle_inputs();
    check_eq("busy_cycles", 32'(n_busy), 32'd15);
    check_eq("busy_no_valid", 32'(bad_valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      read_a(4'(i));
      check_eq("sweep_zero", rd_data_a, 32'h0);
    end

    // 6: reset on the 5th cycle of a sweep
    do_write(4'd9, 32'h99999999, 4'hF);
    do_write(4'd15, 32'hF0F0F0F0, 4'hF);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid_sweep_busy", {31'b0, busy}, 32'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("abort_busy", {31'b0, busy}, 32'h0);
    tick();
    check_eq("abort_busy_stays", {31'b0, busy}, 32'h0);
    rd_en_a = 1'b1; rd_addr_a = 4'd9; rd_en_b = 1'b1; rd_addr_b = 4'd15;
    tick();
    idle_inputs();
    check_eq("abort_valid_a", {31'b0, valid_a}, 32'h1);
    check_eq("abort_addr9",   rd_data_a, 32'h0);
    check_eq("abort_addr15",  rd_data_b, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
